// File: rtl/ddr3_multi_ch_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_multi_ch_wr_arbiter
// Brief    : Round-robin drain of N tagged FWFT write FIFOs into the DDR3 app
//            interface, with per-channel address regions and fill tracking.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_multi_ch_wr_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 128,
    parameter int REGION_W = 21,
    parameter int ADDR_W   = 23,
    parameter int MAX_RUN  = 16,
    localparam int GRANT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TAG_W   = DATA_W + 4
) (
    input  logic                     ddr3_domain_clk,
    input  logic                     reset_n,
    input  logic                     acq_enabled,
    input  logic                     en_fixed_ddr3_start_addr,
    input  logic [REGION_W-1:0]      fixed_ddr3_start_offset,
    input  logic                     clear_status,
    input  logic [NUM_CH-1:0]        ch_fifo_empty,
    input  logic [NUM_CH*TAG_W-1:0]  ch_fifo_dat,
    output logic [NUM_CH-1:0]        ch_fifo_rd_en,
    output logic                     app_en,
    output logic [2:0]               app_cmd,
    output logic [ADDR_W+2:0]        app_addr,
    output logic [DATA_W-1:0]        app_wdf_data,
    output logic                     app_wdf_wren,
    output logic                     app_wdf_end,
    input  logic                     app_rdy,
    input  logic                     app_wdf_rdy,
    output logic [NUM_CH-1:0]        ddr3_wr_done,
    output logic [NUM_CH-1:0]        ddr3_wr_sync_err,
    output logic [GRANT_W-1:0]       grant_ch
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t                r_state;
    logic [GRANT_W-1:0]    r_grant;
    logic [RUN_W-1:0]      r_run_cnt;
    logic                  r_last_loaded;
    logic [REGION_W-1:0]   r_ptr [NUM_CH];
    logic [NUM_CH-1:0]     r_in_fill;
    logic [NUM_CH-1:0]     r_done;
    logic [NUM_CH-1:0]     r_err;
    logic                  r_app_en;
    logic [ADDR_W-1:0]     r_burst;
    logic [DATA_W-1:0]     r_data;
    logic                  r_buf_last;

    logic [TAG_W-1:0]      w_words [NUM_CH];
    logic [TAG_W-1:0]      w_head;
    logic                  w_tag_last;
    logic                  w_tag_hdr;
    logic                  w_grant_empty;
    logic                  w_accept;
    logic                  w_stop;
    logic                  w_pop;
    logic [REGION_W-1:0]   w_word_off;
    logic [REGION_W-1:0]   w_ptr_next;
    logic [ADDR_W-1:0]     w_burst;
    logic                  w_arb_found;
    logic [GRANT_W-1:0]    w_arb_ch;
    logic [GRANT_W-1:0]    w_idx;
    logic                  w_unused_tag;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
            assign w_words[g] = ch_fifo_dat[g*TAG_W +: TAG_W];
        end
    endgenerate

    assign w_head        = w_words[r_grant];
    assign w_tag_last    = w_head[DATA_W+3];
    assign w_tag_hdr     = w_head[DATA_W+2];
    assign w_unused_tag  = ^w_head[DATA_W+1:DATA_W];
    assign w_grant_empty = ch_fifo_empty[r_grant];
    assign w_accept      = r_app_en & app_rdy & app_wdf_rdy;
    assign w_stop        = (r_run_cnt == RUN_W'(MAX_RUN)) | r_last_loaded;
    assign w_pop         = (r_state == ST_XFER) & ~w_grant_empty & (~r_app_en | w_accept) & ~w_stop;

    // A header with fixed-start enabled restarts the region at the programmed offset.
    assign w_word_off = (w_tag_hdr & en_fixed_ddr3_start_addr) ? fixed_ddr3_start_offset : r_ptr[r_grant];
    assign w_ptr_next = w_word_off + REGION_W'(1);
    assign w_burst    = (ADDR_W'(r_grant) << REGION_W) | ADDR_W'(w_word_off);

    // Round-robin search beginning one past the last granted channel.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_ch    = r_grant;
        w_idx       = r_grant;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = (w_idx == GRANT_W'(NUM_CH - 1)) ? '0 : w_idx + GRANT_W'(1);
            if (!w_arb_found && !ch_fifo_empty[w_idx]) begin
                w_arb_found = 1'b1;
                w_arb_ch    = w_idx;
            end
        end
    end

    always_ff @(posedge ddr3_domain_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= GRANT_W'(NUM_CH - 1);
            r_run_cnt     <= '0;
            r_last_loaded <= 1'b0;
            r_in_fill     <= '0;
            r_done        <= '0;
            r_err         <= '0;
            r_app_en      <= 1'b0;
            r_burst       <= '0;
            r_data        <= '0;
            r_buf_last    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_ptr[c] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (acq_enabled && !(&ch_fifo_empty)) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (w_arb_found) begin
                        r_grant       <= w_arb_ch;
                        r_run_cnt     <= '0;
                        r_last_loaded <= 1'b0;
                        r_state       <= ST_XFER;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (!r_app_en && (w_stop || w_grant_empty)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_pop) begin
                r_app_en      <= 1'b1;
                r_burst       <= w_burst;
                r_data        <= w_head[DATA_W-1:0];
                r_buf_last    <= w_tag_last;
                r_last_loaded <= w_tag_last;
                r_run_cnt     <= r_run_cnt + RUN_W'(1);
            end else if (w_accept) begin
                r_app_en <= 1'b0;
            end

            // Clear first so that any set event later in this block takes priority.
            if (clear_status) begin
                r_in_fill <= '0;
                r_done    <= '0;
                r_err     <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    r_ptr[c] <= '0;
                end
            end

            if (w_accept && r_buf_last) begin
                r_done[r_grant] <= 1'b1;
            end

            if (w_pop) begin
                r_ptr[r_grant] <= w_ptr_next;
                if (w_tag_hdr) begin
                    if (r_in_fill[r_grant]) begin
                        r_err[r_grant] <= 1'b1;
                    end
                    r_in_fill[r_grant] <= ~w_tag_last;
                end else begin
                    if (!r_in_fill[r_grant]) begin
                        r_err[r_grant] <= 1'b1;
                    end
                    if (w_tag_last) begin
                        r_in_fill[r_grant] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        ch_fifo_rd_en = '0;
        if (w_pop) begin
            ch_fifo_rd_en[r_grant] = 1'b1;
        end
    end

    assign app_en           = r_app_en;
    assign app_cmd          = 3'b000;
    assign app_addr         = {r_burst, 3'b000};
    assign app_wdf_data     = r_data;
    assign app_wdf_wren     = r_app_en;
    assign app_wdf_end      = r_app_en;
    assign ddr3_wr_done     = r_done;
    assign ddr3_wr_sync_err = r_err;
    assign grant_ch         = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_multi_ch_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_multi_ch_wr_arbiter
// Brief    : Scoreboard bench: FIFO models feed the arbiter, expected writes
//            are queued in arbitration order and compared on every accept.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_multi_ch_wr_arbiter;

    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 128;
    localparam int REGION_W = 21;
    localparam int ADDR_W   = 23;
    localparam int MAX_RUN  = 16;
    localparam int TAG_W    = DATA_W + 4;

    localparam logic [3:0] c_TAG_DATA = 4'b0000;
    localparam logic [3:0] c_TAG_HDR  = 4'b0100;
    localparam logic [3:0] c_TAG_LAST = 4'b1000;
    localparam logic [3:0] c_TAG_BOTH = 4'b1100;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     acq_enabled;
    logic                     en_fixed_ddr3_start_addr;
    logic [REGION_W-1:0]      fixed_ddr3_start_offset;
    logic                     clear_status;
    logic [NUM_CH-1:0]        ch_fifo_empty = '1;
    logic [NUM_CH*TAG_W-1:0]  ch_fifo_dat   = '0;
    logic [NUM_CH-1:0]        ch_fifo_rd_en;
    logic                     app_en;
    logic [2:0]               app_cmd;
    logic [ADDR_W+2:0]        app_addr;
    logic [DATA_W-1:0]        app_wdf_data;
    logic                     app_wdf_wren;
    logic                     app_wdf_end;
    logic                     app_rdy;
    logic                     app_wdf_rdy;
    logic [NUM_CH-1:0]        ddr3_wr_done;
    logic [NUM_CH-1:0]        ddr3_wr_sync_err;
    logic [1:0]               grant_ch;

    always #5 clk = ~clk;

    ddr3_multi_ch_wr_arbiter #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .REGION_W(REGION_W),
        .ADDR_W  (ADDR_W),
        .MAX_RUN (MAX_RUN)
    ) dut (
        .ddr3_domain_clk         (clk),
        .reset_n                 (reset_n),
        .acq_enabled             (acq_enabled),
        .en_fixed_ddr3_start_addr(en_fixed_ddr3_start_addr),
        .fixed_ddr3_start_offset (fixed_ddr3_start_offset),
        .clear_status            (clear_status),
        .ch_fifo_empty           (ch_fifo_empty),
        .ch_fifo_dat             (ch_fifo_dat),
        .ch_fifo_rd_en           (ch_fifo_rd_en),
        .app_en                  (app_en),
        .app_cmd                 (app_cmd),
        .app_addr                (app_addr),
        .app_wdf_data            (app_wdf_data),
        .app_wdf_wren            (app_wdf_wren),
        .app_wdf_end             (app_wdf_end),
        .app_rdy                 (app_rdy),
        .app_wdf_rdy             (app_wdf_rdy),
        .ddr3_wr_done            (ddr3_wr_done),
        .ddr3_wr_sync_err        (ddr3_wr_sync_err),
        .grant_ch                (grant_ch)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] burst;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q [$];
    logic [TAG_W-1:0]  fifo_q [NUM_CH][$];
    logic [NUM_CH-1:0] pop_mask = '0;
    exp_t              mon_e;
    logic [TAG_W-1:0]  pop_word;
    int                n_checks = 0;
    int                n_errors = 0;
    int                n_pop    = 0;
    int                n_acc    = 0;
    int                test_id  = 0;
    logic [ADDR_W+2:0] cap_addr;
    logic [DATA_W-1:0] cap_data;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_data(input int ch, input int idx);
        return (DATA_W'(ch) << 120) | (DATA_W'(test_id) << 64) | DATA_W'(idx);
    endfunction

    task automatic fifo_push(input int ch, input logic [3:0] tag, input int idx);
        fifo_q[ch].push_back({tag, mk_data(ch, idx)});
    endtask

    task automatic exp_push(input int ch, input logic [REGION_W-1:0] off, input int idx);
        exp_t e;
        e.burst = (ADDR_W'(ch) << REGION_W) | ADDR_W'(off);
        e.data  = mk_data(ch, idx);
        exp_q.push_back(e);
    endtask

    task automatic refresh();
        for (int c = 0; c < NUM_CH; c++) begin
            ch_fifo_empty[c] = (fifo_q[c].size() == 0);
            ch_fifo_dat[c*TAG_W +: TAG_W] = (fifo_q[c].size() != 0) ? fifo_q[c][0] : '0;
        end
    endtask

    // FWFT FIFO models: apply the pops seen during the previous cycle.
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pop_mask[c] && fifo_q[c].size() != 0) begin
                pop_word = fifo_q[c].pop_front();
            end
        end
        refresh();
    end

    always @(negedge clk) begin
        pop_mask = reset_n ? ch_fifo_rd_en : '0;
        if (reset_n) begin
            n_pop += $countones(ch_fifo_rd_en);
            if ($countones(ch_fifo_rd_en) > 1) begin
                check("rd_en_onehot", 256'($countones(ch_fifo_rd_en)), 256'd1);
            end
            if (app_en && app_rdy && app_wdf_rdy) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 256'(exp_q.size()), 256'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("app_addr", 256'(app_addr), 256'({mon_e.burst, 3'b000}));
                    check("app_data", 256'(app_wdf_data), 256'(mon_e.data));
                    check("wren_end_cmd", 256'({app_wdf_wren, app_wdf_end, app_cmd}), 256'(5'b11000));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        tick();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    task automatic drain();
        int left;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            left = exp_q.size();
            for (int c = 0; c < NUM_CH; c++) left += fifo_q[c].size();
            if (left == 0 && !app_en) break;
        end
        repeat (2) @(negedge clk);
        left = exp_q.size();
        for (int c = 0; c < NUM_CH; c++) left += fifo_q[c].size();
        check("drain_left", 256'(left), 256'd0);
    endtask

    task automatic run_fill();
        tick();
        acq_enabled = 1'b1;
        drain();
        tick();
        acq_enabled = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n                  = 1'b0;
        acq_enabled              = 1'b0;
        en_fixed_ddr3_start_addr = 1'b0;
        fixed_ddr3_start_offset  = '0;
        clear_status             = 1'b0;
        app_rdy                  = 1'b1;
        app_wdf_rdy              = 1'b1;
        repeat (3) tick();
        check("rst_app_en", 256'(app_en), 256'd0);
        check("rst_rd_en", 256'(ch_fifo_rd_en), 256'd0);
        check("rst_grant", 256'(grant_ch), 256'd3);
        check("rst_done_err", 256'({ddr3_wr_done, ddr3_wr_sync_err}), 256'd0);
        check("rst_addr", 256'(app_addr), 256'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Three-word fill on every channel: grants must come out 0,1,2,3.
        test_id = 1;
        for (int c = 0; c < NUM_CH; c++) begin
            fifo_push(c, c_TAG_HDR, 0);
            fifo_push(c, c_TAG_DATA, 1);
            fifo_push(c, c_TAG_LAST, 2);
            for (int k = 0; k < 3; k++) exp_push(c, REGION_W'(k), k);
        end
        run_fill();
        check("t1_done", 256'(ddr3_wr_done), 256'hF);
        check("t1_err", 256'(ddr3_wr_sync_err), 256'h0);
        check("t1_grant", 256'(grant_ch), 256'd3);
        pulse_clear();
        @(negedge clk);
        check("t1_clr_done", 256'(ddr3_wr_done), 256'h0);

        // Run-length limit plus a write-data stall in the middle of the first run.
        test_id = 2;
        for (int i = 0; i < 40; i++)
            fifo_push(0, (i == 0) ? c_TAG_HDR : ((i == 39) ? c_TAG_LAST : c_TAG_DATA), i);
        for (int i = 0; i < 5; i++)
            fifo_push(1, (i == 0) ? c_TAG_HDR : ((i == 4) ? c_TAG_LAST : c_TAG_DATA), i);
        for (int i = 0;  i < 16; i++) exp_push(0, REGION_W'(i), i);
        for (int i = 0;  i < 5;  i++) exp_push(1, REGION_W'(i), i);
        for (int i = 16; i < 40; i++) exp_push(0, REGION_W'(i), i);
        tick();
        acq_enabled = 1'b1;
        repeat (8) tick();
        app_wdf_rdy = 1'b0;
        @(negedge clk);
        check("stall_app_en", 256'(app_en), 256'd1);
        cap_addr = app_addr;
        cap_data = app_wdf_data;
        repeat (5) begin
            @(negedge clk);
            check("stall_addr", 256'(app_addr), 256'(cap_addr));
            check("stall_data", 256'(app_wdf_data), 256'(cap_data));
            check("stall_rd_en", 256'(ch_fifo_rd_en), 256'd0);
        end
        tick();
        app_wdf_rdy = 1'b1;
        drain();
        tick();
        acq_enabled = 1'b0;
        check("t2_pop_vs_acc", 256'(n_pop), 256'(n_acc));
        check("t2_done", 256'(ddr3_wr_done), 256'h3);
        check("t2_err", 256'(ddr3_wr_sync_err), 256'h0);

        // Pointer wrap inside the ch1 region via a fixed start near the top.
        test_id = 3;
        pulse_clear();
        en_fixed_ddr3_start_addr = 1'b1;
        fixed_ddr3_start_offset  = 21'h1FFFFE;
        fifo_push(1, c_TAG_HDR, 0);
        fifo_push(1, c_TAG_DATA, 1);
        fifo_push(1, c_TAG_LAST, 2);
        exp_push(1, 21'h1FFFFE, 0);
        exp_push(1, 21'h1FFFFF, 1);
        exp_push(1, 21'h000000, 2);
        run_fill();
        en_fixed_ddr3_start_addr = 1'b0;
        fifo_push(1, c_TAG_BOTH, 3);
        exp_push(1, 21'h000001, 3);
        run_fill();
        check("t3_err", 256'(ddr3_wr_sync_err), 256'h0);
        check("t3_done", 256'(ddr3_wr_done), 256'h2);

        // Sync errors: repeated header mid-fill, clear, fixed-offset header, stray data.
        test_id = 4;
        pulse_clear();
        fifo_push(3, c_TAG_HDR, 0);
        fifo_push(3, c_TAG_DATA, 1);
        exp_push(3, 21'h0, 0);
        exp_push(3, 21'h1, 1);
        run_fill();
        check("t4_err_clean", 256'(ddr3_wr_sync_err), 256'h0);
        fifo_push(3, c_TAG_HDR, 2);
        exp_push(3, 21'h2, 2);
        run_fill();
        check("t4_err_hdr", 256'(ddr3_wr_sync_err), 256'h8);
        pulse_clear();
        @(negedge clk);
        check("t4_err_cleared", 256'(ddr3_wr_sync_err), 256'h0);
        en_fixed_ddr3_start_addr = 1'b1;
        fixed_ddr3_start_offset  = 21'h100;
        fifo_push(3, c_TAG_BOTH, 3);
        exp_push(3, 21'h100, 3);
        run_fill();
        en_fixed_ddr3_start_addr = 1'b0;
        check("t4_err_fixed", 256'(ddr3_wr_sync_err), 256'h0);
        check("t4_done_fixed", 256'(ddr3_wr_done), 256'h8);
        fifo_push(2, c_TAG_DATA, 0);
        exp_push(2, 21'h0, 0);
        run_fill();
        check("t4_err_stray", 256'(ddr3_wr_sync_err), 256'h4);

        // Reset asserted with a word held in the output buffer.
        test_id = 5;
        app_rdy = 1'b0;
        for (int i = 0; i < 10; i++) fifo_push(1, (i == 0) ? c_TAG_HDR : c_TAG_DATA, i);
        tick();
        acq_enabled = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (app_en) break;
        end
        check("t5_pre_app_en", 256'(app_en), 256'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_app_en", 256'(app_en), 256'd0);
        check("t5_rst_rd_en", 256'(ch_fifo_rd_en), 256'd0);
        check("t5_rst_grant", 256'(grant_ch), 256'd3);
        fifo_q[1].delete();
        acq_enabled = 1'b0;
        app_rdy     = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        test_id = 6;
        fifo_push(1, c_TAG_BOTH, 0);
        fifo_push(0, c_TAG_BOTH, 0);
        exp_push(0, 21'h0, 0);
        exp_push(1, 21'h0, 0);
        run_fill();
        check("t5_done", 256'(ddr3_wr_done), 256'h3);
        check("t5_err", 256'(ddr3_wr_sync_err), 256'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr3_multi_ch_wr_arbiter.md
Name: ddr3_multi_ch_wr_arbiter

Overview:
- Generalised DDR3 write path. Replaces the single-channel FIFO-to-DDR3 write control with an N-channel round-robin arbiter.
- Each ADC channel has its own tagged write FIFO (first-word-fall-through). The arbiter drains these FIFOs into the DDR3 user interface.
- Each channel owns a private address region, with per-channel write pointers, fill-boundary tracking and done/sync-error flags.
- Sits in the ddr3_domain_clk domain, between the per-channel ddr3_write_fifo instances and the DDR3 controller app interface.

Parameters:
- NUM_CH, 4, number of channel FIFOs arbitrated (1..16).
- DATA_W, 128, payload bits per FIFO word.
- REGION_W, 21, log2 of bursts per channel region.
- ADDR_W, 23, burst-address width; must satisfy ADDR_W >= REGION_W + clog2(NUM_CH).
- MAX_RUN, 16, maximum words transferred per grant before re-arbitration.

Ports:
- ddr3_domain_clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- acq_enabled  in  1  when low, no new grants are issued; the current run completes.
- en_fixed_ddr3_start_addr  in  1  reload pointer at each fill start.
- fixed_ddr3_start_offset  in  REGION_W  offset loaded when the above is set.
- clear_status  in  1  one-cycle pulse: clears done/err flags and zeros all pointers.
- ch_fifo_empty  in  NUM_CH  per-channel FIFO empty.
- ch_fifo_dat  in  NUM_CH*(DATA_W+4)  per-channel head word. Tag is bits [DATA_W+3:DATA_W]: bit3=last word of fill, bit2=first word (header).
- ch_fifo_rd_en  out  NUM_CH  pop head word; one-hot or zero.
- app_en  out  1  command valid.
- app_cmd  out  3  fixed 3'b000 (write).
- app_addr  out  ADDR_W+3  {burst address, 3'b000}.
- app_wdf_data  out  DATA_W  write data.
- app_wdf_wren  out  1  equals app_en.
- app_wdf_end  out  1  equals app_en.
- app_rdy  in  1  controller command ready.
- app_wdf_rdy  in  1  controller write-data ready.
- ddr3_wr_done  out  NUM_CH  sticky: last-of-fill word accepted for that channel.
- ddr3_wr_sync_err  out  NUM_CH  sticky: header tag seen mid-fill, or data seen outside a fill.
- grant_ch  out  clog2(NUM_CH)  currently/last granted channel (debug).

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE; all outputs 0; grant_ch=NUM_CH-1.
  - Pointers=0; in_fill=0 for all channels.
- Accept condition: accept = app_en & app_rdy & app_wdf_rdy. Command and data are always presented together. app_en holds stable, with address and data unchanged, until accept.
- States:
  - IDLE: if acq_enabled and any channel is non-empty, go to ARB.
  - ARB (1 cycle): round-robin search starting at grant_ch+1 (mod NUM_CH). Pick the first non-empty channel, latch it into grant_ch, run_cnt=0, go to XFER. If all are empty, return to IDLE.
  - XFER:
    - Output register (app_en/addr/data) is a 1-entry buffer.
    - ch_fifo_rd_en[g] = ~ch_fifo_empty[g] & (~app_en | accept) & ~stop, where stop = run_cnt==MAX_RUN or last-of-fill already loaded.
    - On a pop: load the word next cycle, app_en=1, app_addr = {g, ptr[g]} zero-extended, ptr[g] += 1 mod 2^REGION_W (wraps inside region), run_cnt += 1.
    - Leave XFER to IDLE when the buffer is empty and either stop is set or the FIFO is empty. Minimum 2 idle cycles between grants; back-to-back words within a grant sustain 1 word/cycle.
- Fill tracking, evaluated at pop:
  - Header tag: if in_fill[g] is already 1, set sync_err[g]. Then set in_fill[g]=1. If en_fixed_ddr3_start_addr, this word uses fixed_ddr3_start_offset and ptr becomes offset+1.
  - Non-header with in_fill[g]=0: set sync_err[g]. The word is still written.
  - Last tag: in_fill[g] clears at pop. ddr3_wr_done[g] sets on accept of that word. Header+last in one word is legal.
- clear_status:
  - Clears done, err, ptr and in_fill.
  - If a set event for the same bit occurs in the same cycle, the set wins.
  - A word already in the output buffer keeps its address.
- acq_enabled fall mid-XFER: the current run finishes normally. It only blocks IDLE→ARB.
- Stall with app_rdy or app_wdf_rdy low: no pops; the buffer holds; no counters change.

Test Plan:
- NUM_CH=4; all FIFOs hold 3 words each (header, data, last); app_rdy=app_wdf_rdy=1 → grants in order 0,1,2,3; ch2 addresses 0x400000,0x400001,0x400002 (<<3 on app_addr); ddr3_wr_done=4'b1111; no errors.
- ch0 holds 40 words, ch1 holds 5 words, MAX_RUN=16 → transfer order: ch0 16, ch1 5, ch0 16, ch0 8; ch0 burst addresses 0..39 contiguous.
- app_wdf_rdy low for 5 cycles mid-run → app_en, addr and data held constant; exactly one pop per accept; no word lost or duplicated.
- ptr[1] preset by writing 2^21-1 words, then 2 more → addresses 0x3FFFFF... wrap to region offset 0, i.e. 0x200000; never enters ch2 region.
- Header tag arrives on ch3 mid-fill → sync_err[3]=1 next cycle; clear_status pulse → 0. en_fixed_ddr3_start_addr=1 with offset 0x100 → ch3 header written at 0x600100.
- reset_n asserted mid-XFER with app_en=1 → app_en=0 and rd_en=0 immediately; after release, pointers=0 and first grant goes to ch0.
